// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: turns frame pulses and button presses into paced head moves and runs start/pause/over sequencing and the score
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   frame_pulse                one-cycle pulse per video frame
//   btn_up/down/left/right     debounced press pulses for steering
//   btn_center                 start / pause / resume / restart
//   step_req, step_ack         move handshake with the body engine (head_x/head_y valid while step_req)
//   step_hit, step_grow        move result, sampled with step_ack
//   clear_req                  one-cycle board clear on game start
//   head_x, head_y, direction  head cell and committed heading (00 right, 01 left, 10 up, 11 down)
//   state                      00 idle, 01 run, 10 pause, 11 over
//   score                      saturating food count
module snake_game_sequencer #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int TICK_FRAMES = 6,
  parameter int START_X     = 20,
  parameter int START_Y     = 15,
  parameter int XW          = $clog2(GRID_W),
  parameter int YW          = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_pulse,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_center,
  output logic          step_req,
  input  logic          step_ack,
  input  logic          step_hit,
  input  logic          step_grow,
  output logic          clear_req,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    direction,
  output logic [1:0]    state,
  output logic [7:0]    score
);
  localparam int CW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_PAUSE, S_OVER} fsm_t;
  fsm_t fsm;
  logic [1:0] pend, win, ref_dir;
  logic [CW-1:0] cnt;
  logic tick, any_dir, reject, wall, moving;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  always_comb begin
    tick = frame_pulse && cnt == CW'(TICK_FRAMES - 1);
    any_dir = btn_up | btn_down | btn_left | btn_right;
    win = btn_up ? 2'b10 : btn_down ? 2'b11 : btn_left ? 2'b01 : 2'b00;
    wall = pend == 2'b00 ? head_x == XW'(GRID_W - 1) :
           pend == 2'b01 ? head_x == '0 :
           pend == 2'b10 ? head_y == '0 : head_y == YW'(GRID_H - 1);
    moving = fsm == S_RUN && tick && !wall;
    // a press landing on the move edge is checked against the heading being committed, so it can never reverse it
    ref_dir = moving ? pend : direction;
    reject = win == {ref_dir[1], ~ref_dir[0]};
    nx = pend == 2'b00 ? head_x + XW'(1) : pend == 2'b01 ? head_x - XW'(1) : head_x;
    ny = pend == 2'b10 ? head_y - YW'(1) : pend == 2'b11 ? head_y + YW'(1) : head_y;
    state = fsm == S_IDLE ? 2'b00 : fsm == S_PAUSE ? 2'b10 : fsm == S_OVER ? 2'b11 : 2'b01;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= S_IDLE;
      head_x <= XW'(START_X);
      head_y <= YW'(START_Y);
      direction <= 2'b00;
      pend <= 2'b00;
      score <= '0;
      cnt <= '0;
      step_req <= 1'b0;
      clear_req <= 1'b0;
    end else begin
      clear_req <= 1'b0;
      case (fsm)
        S_IDLE: begin
          cnt <= '0;
          if (btn_center) begin
            clear_req <= 1'b1;
            fsm <= S_RUN;
          end
        end
        S_RUN: begin
          if (any_dir && !reject) pend <= win;
          if (frame_pulse) cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            if (wall) fsm <= S_OVER;
            else begin
              head_x <= nx;
              head_y <= ny;
              direction <= pend;
              step_req <= 1'b1;
              fsm <= S_WAIT;
            end
          end else if (btn_center) fsm <= S_PAUSE;
        end
        S_WAIT: begin
          if (any_dir && !reject) pend <= win;
          // ticks arriving while the body engine is busy are dropped
          if (frame_pulse) cnt <= tick ? '0 : cnt + CW'(1);
          if (step_ack) begin
            step_req <= 1'b0;
            if (step_hit) fsm <= S_OVER;
            else begin
              if (step_grow && score != 8'hff) score <= score + 8'd1;
              fsm <= S_RUN;
            end
          end
        end
        S_PAUSE: if (btn_center) fsm <= S_RUN;
        S_OVER: if (btn_center) begin
          head_x <= XW'(START_X);
          head_y <= YW'(START_Y);
          direction <= 2'b00;
          pend <= 2'b00;
          score <= '0;
          fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_snake_game_sequencer.sv
// tb_snake_game_sequencer: scenario tasks with a queue of expected moves for snake_game_sequencer
module tb_snake_game_sequencer;
  logic clk = 0, rst_n = 0, frame_pulse = 0, step_ack = 0, step_hit = 0, step_grow = 0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
  logic step_req, clear_req, e_step_req, e_clear_req;
  logic [5:0] head_x, e_head_x;
  logic [4:0] head_y, e_head_y;
  logic [1:0] direction, state, e_direction, e_state;
  logic [7:0] score, e_score;
  int total = 0, bad = 0;
  typedef struct {int x; int y; int d;} step_t;
  step_t sb[$];
  always #5 clk = ~clk;
  snake_game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_pulse(frame_pulse),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_center(btn_center),
    .step_req(step_req), .step_ack(step_ack), .step_hit(step_hit), .step_grow(step_grow),
    .clear_req(clear_req), .head_x(head_x), .head_y(head_y), .direction(direction), .state(state), .score(score));
  snake_game_sequencer #(.START_X(38)) dut_edge (
    .clk(clk), .rst_n(rst_n), .frame_pulse(frame_pulse),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_center(btn_center),
    .step_req(e_step_req), .step_ack(step_ack), .step_hit(step_hit), .step_grow(step_grow),
    .clear_req(e_clear_req), .head_x(e_head_x), .head_y(e_head_y), .direction(e_direction), .state(e_state), .score(e_score));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic btn(input logic [4:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_center} = b;
    cyc();
    {btn_up, btn_down, btn_left, btn_right, btn_center} = '0;
  endtask
  task automatic frame();
    frame_pulse = 1;
    cyc();
    frame_pulse = 0;
    cyc();
  endtask
  task automatic ack(input logic hit, input logic grow);
    step_ack = 1;
    step_hit = hit;
    step_grow = grow;
    cyc();
    {step_ack, step_hit, step_grow} = '0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    sb.delete();
  endtask
  task automatic test_reset();
    rst_n = 0;
    cyc();
    cyc();
    total++;
    if ({state, head_x, head_y, direction, score} !== {2'b00, 6'd20, 5'd15, 2'b00, 8'd0}) begin
      bad++;
      $display("FAIL reset_state got st=%0d x=%0d y=%0d d=%0d sc=%0d exp st=0 x=20 y=15 d=0 sc=0", state, head_x, head_y, direction, score);
    end
    total++;
    if ({step_req, clear_req} !== 2'b00) begin
      bad++;
      $display("FAIL reset_req got req=%b clr=%b exp 0 0", step_req, clear_req);
    end
    rst_n = 1;
    cyc();
  endtask
  task automatic test_start();
    step_t e;
    btn(5'b00001);
    total++;
    if ({clear_req, state} !== 3'b1_01) begin
      bad++;
      $display("FAIL start_clear got clr=%b st=%0d exp clr=1 st=1", clear_req, state);
    end
    cyc();
    total++;
    if (clear_req !== 1'b0) begin
      bad++;
      $display("FAIL start_clear_width got clr=%b exp 0", clear_req);
    end
    sb.push_back('{21, 15, 0});
    repeat (5) frame();
    total++;
    if (step_req !== 1'b0) begin
      bad++;
      $display("FAIL start_early_req got=%b exp=0", step_req);
    end
    frame();
    for (int i = 0; i < 4 && !step_req; i++) cyc();
    total++;
    if (step_req !== 1'b1) begin
      bad++;
      $display("FAIL start_req got=%b exp=1", step_req);
    end else begin
      e = sb.pop_front();
      total++;
      if ({head_x, head_y, direction} !== {6'(e.x), 5'(e.y), 2'(e.d)}) begin
        bad++;
        $display("FAIL start_step got %0d,%0d,%0d exp %0d,%0d,%0d", head_x, head_y, direction, e.x, e.y, e.d);
      end
    end
    ack(0, 0);
    total++;
    if ({step_req, score, state} !== {1'b0, 8'd0, 2'b01}) begin
      bad++;
      $display("FAIL start_ack got req=%b sc=%0d st=%0d exp req=0 sc=0 st=1", step_req, score, state);
    end
  endtask
  task automatic test_direction();
    step_t e;
    btn(5'b00100);
    btn(5'b10000);
    sb.push_back('{21, 14, 2});
    repeat (6) frame();
    total++;
    if (step_req !== 1'b1) begin
      bad++;
      $display("FAIL dir_req got=%b exp=1", step_req);
    end else begin
      e = sb.pop_front();
      total++;
      if ({head_x, head_y, direction} !== {6'(e.x), 5'(e.y), 2'(e.d)}) begin
        bad++;
        $display("FAIL dir_step got %0d,%0d,%0d exp %0d,%0d,%0d", head_x, head_y, direction, e.x, e.y, e.d);
      end
    end
    ack(0, 0);
  endtask
  task automatic test_stall();
    step_t e;
    int errs = 0;
    sb.push_back('{21, 13, 2});
    repeat (6) frame();
    total++;
    if (step_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_req got=%b exp=1", step_req);
    end else begin
      e = sb.pop_front();
      total++;
      if ({head_x, head_y, direction} !== {6'(e.x), 5'(e.y), 2'(e.d)}) begin
        bad++;
        $display("FAIL stall_step got %0d,%0d,%0d exp %0d,%0d,%0d", head_x, head_y, direction, e.x, e.y, e.d);
      end
    end
    for (int i = 0; i < 20; i++) begin
      frame();
      total++;
      if ({step_req, head_x, head_y} !== {1'b1, 6'd21, 5'd13}) begin
        bad++;
        $display("FAIL stall_hold frame %0d got req=%b x=%0d y=%0d exp req=1 x=21 y=13", i, step_req, head_x, head_y);
      end
    end
    ack(1, 1);
    total++;
    if ({step_req, state, score} !== {1'b0, 2'b11, 8'd0}) begin
      bad++;
      $display("FAIL stall_hit got req=%b st=%0d sc=%0d exp req=0 st=3 sc=0", step_req, state, score);
    end
  endtask
  task automatic test_score();
    step_t e;
    int x = 20, y = 15, d, sc = 0;
    btn(5'b00001);
    total++;
    if ({state, head_x, head_y, direction, score} !== {2'b00, 6'd20, 5'd15, 2'b00, 8'd0}) begin
      bad++;
      $display("FAIL restart_idle got st=%0d x=%0d y=%0d d=%0d sc=%0d exp 0 20 15 0 0", state, head_x, head_y, direction, score);
    end
    btn(5'b00001);
    for (int k = 0; k < 256; k++) begin
      d = k % 4 == 0 ? 0 : k % 4 == 1 ? 2 : k % 4 == 2 ? 1 : 3;
      btn(d == 2 ? 5'b10000 : d == 3 ? 5'b01000 : d == 1 ? 5'b00100 : 5'b00010);
      x += d == 0 ? 1 : d == 1 ? -1 : 0;
      y += d == 2 ? -1 : d == 3 ? 1 : 0;
      sb.push_back('{x, y, d});
      repeat (6) frame();
      total++;
      if (step_req !== 1'b1) begin
        bad++;
        $display("FAIL score_req step %0d got=%b exp=1", k, step_req);
      end else begin
        e = sb.pop_front();
        total++;
        if ({head_x, head_y, direction} !== {6'(e.x), 5'(e.y), 2'(e.d)}) begin
          bad++;
          $display("FAIL score_step %0d got %0d,%0d,%0d exp %0d,%0d,%0d", k, head_x, head_y, direction, e.x, e.y, e.d);
        end
      end
      ack(0, 1);
      sc = sc < 255 ? sc + 1 : 255;
      total++;
      if (score !== 8'(sc)) begin
        bad++;
        $display("FAIL score_val step %0d got=%0d exp=%0d", k, score, sc);
      end
    end
  endtask
  task automatic test_edge();
    do_reset();
    btn(5'b00001);
    repeat (6) frame();
    total++;
    if ({e_step_req, e_head_x} !== {1'b1, 6'd39}) begin
      bad++;
      $display("FAIL edge_first got req=%b x=%0d exp req=1 x=39", e_step_req, e_head_x);
    end
    ack(0, 1);
    repeat (6) frame();
    total++;
    if ({e_step_req, e_state, e_head_x} !== {1'b0, 2'b11, 6'd39}) begin
      bad++;
      $display("FAIL edge_over got req=%b st=%0d x=%0d exp req=0 st=3 x=39", e_step_req, e_state, e_head_x);
    end
    btn(5'b00001);
    total++;
    if ({e_state, e_head_x, e_score} !== {2'b00, 6'd38, 8'd0}) begin
      bad++;
      $display("FAIL edge_restart got st=%0d x=%0d sc=%0d exp st=0 x=38 sc=0", e_state, e_head_x, e_score);
    end
  endtask
  task automatic test_pause();
    int errs = 0;
    do_reset();
    btn(5'b00001);
    btn(5'b00001);
    total++;
    if (state !== 2'b10) begin
      bad++;
      $display("FAIL pause_enter got st=%0d exp=2", state);
    end
    for (int i = 0; i < 10; i++) begin
      frame();
      total++;
      if ({step_req, state} !== 3'b0_10) begin
        bad++;
        $display("FAIL pause_hold frame %0d got req=%b st=%0d exp req=0 st=2", i, step_req, state);
      end
    end
    btn(5'b00001);
    repeat (5) frame();
    total++;
    if ({step_req, state} !== 3'b0_01) begin
      bad++;
      $display("FAIL pause_resume got req=%b st=%0d exp req=0 st=1", step_req, state);
    end
    frame();
    total++;
    if ({step_req, head_x, head_y} !== {1'b1, 6'd21, 5'd15}) begin
      bad++;
      $display("FAIL pause_step got req=%b x=%0d y=%0d exp req=1 x=21 y=15", step_req, head_x, head_y);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({step_req, state, head_x} !== {1'b0, 2'b00, 6'd20}) begin
      bad++;
      $display("FAIL async_reset got req=%b st=%0d x=%0d exp req=0 st=0 x=20", step_req, state, head_x);
    end
    cyc();
    rst_n = 1;
    cyc();
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_start();
    test_direction();
    test_stall();
    test_score();
    test_edge();
    test_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Central game-state controller for the VGA snake game. It converts debounced button pulses and a once-per-frame pulse into paced movement steps, and tracks the head position and direction. Each move is handed to the snake body/board engine over a request/acknowledge handshake. It also owns the start/pause/game-over sequencing and the score. It sits between the button conditioning logic and the body engine and renderer inside the top-level game module.

## Interface
- GRID_W, 40: board width in cells; XW = $clog2(GRID_W)
- GRID_H, 30: board height in cells; YW = $clog2(GRID_H)
- TICK_FRAMES, 6: frames per move, ≥1
- START_X, 20 / START_Y, 15: head cell after reset or restart

- Clock  in  1  system clock, all logic rising-edge
- ResetN  in  1  asynchronous, active-low reset
- FramePulse  in  1  one-cycle pulse per VGA frame
- BtnUp, BtnDown, BtnLeft, BtnRight, BtnCenter  in  1 each  debounced one-cycle press pulses
- StepReq  out  1  move request to body engine; valid with HeadX/HeadY
- StepAck  in  1  one-cycle completion from body engine
- StepHit  in  1  sampled with StepAck: head hit body
- StepGrow  in  1  sampled with StepAck: head ate food
- ClearReq  out  1  one-cycle board-clear pulse on game start
- HeadX  out  XW  head column; HeadY  out  YW  head row
- Direction  out  2  00 right, 01 left, 10 up, 11 down
- State  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
- Score  out  8  food count, saturating

## Operation
- Internal FSM has five states: IDLE, RUN, WAIT, PAUSE, OVER. WAIT is reported on State as 01 (RUN).
- Reset values:
  - State IDLE, HeadX START_X, HeadY START_Y, Direction 00.
  - Pending direction 00, Score 0, frame counter 0.
  - StepReq 0, ClearReq 0.
- IDLE:
  - BtnCenter causes ClearReq high for exactly 1 cycle and moves to RUN.
  - Frame counter is cleared to 0.
- RUN, direction buttons:
  - A direction button loads the pending direction.
  - Reversal of the committed Direction is rejected (right↔left, up↔down).
  - Simultaneous presses resolve by priority Up > Down > Left > Right. A rejected winner loads nothing.
- RUN, movement tick:
  - Each FramePulse increments the frame counter.
  - The pulse that finds the counter at TICK_FRAMES-1 is a tick. On a tick the counter goes to 0.
  - On a tick, compute the next head cell from the pending direction.
  - If the next cell is outside the board, go to OVER. Outside means X=0 moving left, X=GRID_W-1 moving right, Y=0 moving up, or Y=GRID_H-1 moving down. The head does not move and no StepReq is issued.
  - Otherwise, on the same edge: load HeadX/HeadY with the new cell, load Direction from pending, set StepReq to 1, and go to WAIT.
- RUN, other input: BtnCenter with no tick in that cycle goes to PAUSE. If a tick and BtnCenter arrive together, the tick wins and Center is dropped.
- WAIT:
  - StepReq stays high until StepAck.
  - On StepAck: StepReq goes to 0 on the same edge.
    - StepHit=1 goes to OVER; Score is unchanged even if StepGrow=1.
    - Otherwise, StepGrow=1 increments Score, saturating at 255, and the FSM returns to RUN.
  - Direction buttons keep loading pending direction, with the reversal check against the committed Direction.
  - FramePulse still advances the counter. A tick that lands in WAIT is dropped and the counter wraps to 0.
  - BtnCenter is ignored.
- PAUSE: the frame counter is frozen and direction buttons are ignored. BtnCenter returns to RUN.
- OVER:
  - All outputs hold.
  - BtnCenter goes to IDLE and restores the reset values of HeadX, HeadY, Direction, pending direction and Score.
- StepAck outside WAIT is ignored.

## Timing
- A tick sampled at edge N gives StepReq=1 and the updated HeadX/HeadY/Direction after edge N.
- With StepAck=1 sampled at edge M: StepReq=0 and the State/Score update are visible after edge M.
- Minimum StepReq high time is 1 cycle, for a zero-wait ack.
- With TICK_FRAMES=1, every FramePulse while in RUN is a tick.
- ResetN assertion at any time, including mid-WAIT, forces all reset values immediately, asynchronously. Deassertion is taken synchronously on the next edge.
- ClearReq and StepReq are never high in the same cycle.

## Test plan
- Reset, BtnCenter, then 6 FramePulses → ClearReq is one pulse. StepReq rises after the 6th pulse with HeadX=21, HeadY=15. Ack with Grow=0 → Score stays 0 and State is 01.
- In RUN heading right, BtnLeft then BtnUp before the tick → Left rejected and Up pending. Next step gives HeadY=14, Direction=10.
- Hold StepAck low for 20 frames in WAIT → StepReq stays high, no second request is issued, and HeadX is unchanged. Then ack with StepHit=1 → State 11.
- 255 steps acked with StepGrow=1, then one more → Score is 255 and stays 255.
- Start at START_X=GRID_W-2 heading right, two ticks → first tick gives HeadX=39. Second tick gives OVER with no StepReq. BtnCenter → IDLE with HeadX=START_X and Score=0.
- Pause: BtnCenter in RUN, 10 FramePulses, BtnCenter → no StepReq while paused. The first step comes after 6 further frames. Also assert ResetN low mid-WAIT → StepReq=0 and State 00 immediately.
